auto_player_ctl: RTL and testbench

Parametrised AI paddle controller: the next generation of the single-paddle auto player. It drives the paddle-movement block with the usual active-low plus/minus strobes. New behaviour over the previous generation:
- configurable coordinate width
- dead-zone around the target, to stop jitter
- reaction-delay counter, to set difficulty
- "return to centre" mode that parks the paddle at a programmable home row while the ball travels away

It sits between the ball/paddle position registers and the paddle movement module.

---
 rtl/auto_player_ctl.sv | 125 ++++++++++++
 tb/tb_auto_player_ctl.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/auto_player_ctl.sv
// auto_player_ctl: AI paddle controller with dead-zone, reaction delay
// and return-to-home parking; drives active-low plus/minus strobes.
//
// Ports:
//   clk    in        system clock, rising edge
//   rst    in        asynchronous active-low reset
//   en     in        controller enable; low forces HOLD / stopped
//   turn   in        this paddle's turn (mode 10)
//   xh     in        ball heading toward this paddle
//   mode   in  [1:0] 00 xh, 01 always, 10 turn, 11 xh + return-home
//   by     in  [W-1:0] ball y
//   py     in  [W-1:0] paddle y
//   p      out       plus strobe, active-low (toward larger y)
//   m      out       minus strobe, active-low (toward smaller y)
//   state  out [1:0] 00 HOLD, 01 TRACK, 10 RETURN
module auto_player_ctl #(
    parameter int unsigned W      = 11,
    parameter int unsigned DEAD   = 4,
    parameter int unsigned REACT  = 8,
    parameter int unsigned HOME_Y = 240
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         turn,
    input  logic         xh,
    input  logic [1:0]   mode,
    input  logic [W-1:0] by,
    input  logic [W-1:0] py,
    output logic         p,
    output logic         m,
    output logic [1:0]   state
);

    typedef enum logic [1:0] {
        S_HOLD   = 2'b00,
        S_TRACK  = 2'b01,
        S_RETURN = 2'b10
    } state_t;

    localparam int unsigned CW = (REACT > 1) ? $clog2(REACT) : 1;
    localparam logic [CW-1:0] RELOAD = CW'(REACT - 1);
    localparam logic [W-1:0]  HOME   = W'(HOME_Y);
    // Dead-zone held in 64 bits so values of 2^W and above simply
    // never let the paddle move.
    localparam logic signed [63:0] DEAD_S = 64'(DEAD);

    state_t        state_q, state_d;
    logic          p_q, p_d;
    logic          m_q, m_d;
    logic [CW-1:0] cnt_q;

    logic                engage;
    logic [W-1:0]        tgt;
    logic signed [W:0]   diff;
    logic signed [63:0]  diff_x;
    logic                go_plus;
    logic                go_minus;

    always_comb begin
        engage = 1'b0;
        unique case (mode)
            2'b00:   engage = xh;
            2'b01:   engage = 1'b1;
            2'b10:   engage = turn;
            2'b11:   engage = xh;
            default: engage = 1'b0;
        endcase
    end

    always_comb begin
        state_d = S_HOLD;
        if (engage)
            state_d = S_TRACK;
        else if (mode == 2'b11)
            state_d = S_RETURN;
    end

    assign tgt = (state_d == S_RETURN) ? HOME : by;

    // One extra bit keeps the unsigned difference exact.
    assign diff   = $signed({1'b0, tgt}) - $signed({1'b0, py});
    assign diff_x = {{(64 - W - 1){diff[W]}}, diff};

    assign go_plus  = diff_x > DEAD_S;
    assign go_minus = diff_x < -DEAD_S;

    always_comb begin
        p_d = 1'b1;
        m_d = 1'b1;
        if (state_d != S_HOLD) begin
            if (go_plus)
                p_d = 1'b0;
            else if (go_minus)
                m_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_HOLD;
            p_q     <= 1'b1;
            m_q     <= 1'b1;
            cnt_q   <= '0;
        end else if (!en) begin
            // Abort any countdown so the first enabled edge decides.
            state_q <= S_HOLD;
            p_q     <= 1'b1;
            m_q     <= 1'b1;
            cnt_q   <= '0;
        end else if (cnt_q == '0) begin
            state_q <= state_d;
            p_q     <= p_d;
            m_q     <= m_d;
            cnt_q   <= RELOAD;
        end else begin
            cnt_q   <= cnt_q - 1'b1;
        end
    end

    assign p     = p_q;
    assign m     = m_q;
    assign state = state_q;

endmodule

// File: tb/tb_auto_player_ctl.sv
// Directed bench for auto_player_ctl: one REACT=1 and one REACT=8
// instance on shared stimulus, plus a random strobe-exclusion run.
module tb_auto_player_ctl;

    localparam int W = 11;

    logic         clk = 1'b0;
    logic         rst;
    logic         en;
    logic         turn;
    logic         xh;
    logic [1:0]   mode;
    logic [W-1:0] by;
    logic [W-1:0] py;

    logic       p1, m1, p8, m8;
    logic [1:0] s1, s8;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    auto_player_ctl #(.W(W), .DEAD(4), .REACT(1), .HOME_Y(240)) u1 (
        .clk(clk), .rst(rst), .en(en), .turn(turn), .xh(xh),
        .mode(mode), .by(by), .py(py),
        .p(p1), .m(m1), .state(s1)
    );

    auto_player_ctl #(.W(W), .DEAD(4), .REACT(8), .HOME_Y(240)) u8 (
        .clk(clk), .rst(rst), .en(en), .turn(turn), .xh(xh),
        .mode(mode), .by(by), .py(py),
        .p(p8), .m(m8), .state(s8)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // obs/exp packed as {p, m, state}
    task automatic chk(input string tag, input logic [3:0] obs,
                       input logic [3:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    initial begin
        rst  = 1'b0;
        en   = 1'b1;
        turn = 1'b0;
        xh   = 1'b0;
        mode = 2'b01;
        by   = 11'd100;
        py   = 11'd50;

        step();
        step();
        chk("rst_u1", {p1, m1, s1}, 4'b1100);
        chk("rst_u8", {p8, m8, s8}, 4'b1100);

        rst = 1'b1;
        step();
        chk("first_u1", {p1, m1, s1}, 4'b0101);
        chk("first_u8", {p8, m8, s8}, 4'b0101);

        // Reaction delay on u8
        by = 11'd300;
        py = 11'd200;
        for (int i = 0; i < 8; i++) step();
        chk("react_dec_u8", {p8, m8, s8}, 4'b0101);
        by = 11'd10;
        for (int i = 0; i < 7; i++) begin
            step();
            chk("react_hold_u8", {p8, m8, s8}, 4'b0101);
            chk("react_u1", {p1, m1, s1}, 4'b1001);
        end
        step();
        chk("react_new_u8", {p8, m8, s8}, 4'b1001);

        // Dead-zone on u1
        py = 11'd100;
        by = 11'd104;
        step();
        chk("dz_plus4", {p1, m1, s1}, 4'b1101);
        by = 11'd105;
        step();
        chk("dz_plus5", {p1, m1, s1}, 4'b0101);
        by = 11'd95;
        step();
        chk("dz_minus5", {p1, m1, s1}, 4'b1001);
        by = 11'd96;
        step();
        chk("dz_minus4", {p1, m1, s1}, 4'b1101);
        by = 11'd0;
        py = 11'd2047;
        step();
        chk("dz_extreme", {p1, m1, s1}, 4'b1001);

        // Return-home on u1
        mode = 2'b11;
        xh   = 1'b1;
        by   = 11'd400;
        py   = 11'd300;
        step();
        chk("ret_track", {p1, m1, s1}, 4'b0101);
        xh = 1'b0;
        step();
        chk("ret_down", {p1, m1, s1}, 4'b1010);
        py = 11'd243;
        step();
        chk("ret_park", {p1, m1, s1}, 4'b1110);
        py = 11'd235;
        step();
        chk("ret_up", {p1, m1, s1}, 4'b0110);

        // Mode gating on u1
        mode = 2'b10;
        turn = 1'b0;
        xh   = 1'b1;
        step();
        chk("gate_noturn", {p1, m1, s1}, 4'b1100);
        turn = 1'b1;
        by   = 11'd300;
        py   = 11'd100;
        step();
        chk("gate_turn", {p1, m1, s1}, 4'b0101);
        mode = 2'b00;
        xh   = 1'b0;
        step();
        chk("gate_m00", {p1, m1, s1}, 4'b1100);

        // en abort on u8
        en = 1'b0;
        step();
        chk("en_low_u1", {p1, m1, s1}, 4'b1100);
        chk("en_low_u8", {p8, m8, s8}, 4'b1100);
        en   = 1'b1;
        mode = 2'b01;
        by   = 11'd300;
        py   = 11'd100;
        step();
        chk("en_dec_u8", {p8, m8, s8}, 4'b0101);
        step();
        step();
        by = 11'd10;
        en = 1'b0;
        step();
        chk("abort_u8", {p8, m8, s8}, 4'b1100);
        en = 1'b1;
        step();
        chk("resume_u8", {p8, m8, s8}, 4'b1001);
        chk("resume_u1", {p1, m1, s1}, 4'b1001);

        // Random run: strobes never both active
        for (int i = 0; i < 10000; i++) begin
            by   = W'($urandom);
            py   = W'($urandom);
            mode = 2'($urandom);
            xh   = 1'($urandom);
            turn = 1'($urandom);
            en   = ($urandom_range(0, 7) != 0);
            step();
            total++;
            assert ((p1 | m1) === 1'b1 && (p8 | m8) === 1'b1) else begin
                bad++;
                $error("FAIL rnd_excl observed=%b%b%b%b expected=no 00 pair",
                       p1, m1, p8, m8);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
